// File: rtl/seg_scan_if.sv
// Write/commit port of the seven-segment scan controller.
// The requester drives the master side and the controller answers on the slave side.
interface seg_scan_if;
  logic       wr_en;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       commit;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output wr_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 6-digit multiplexed seven-segment display: shadow/active digit
// files with tear-free frame-boundary commit, anti-ghost blanking and 16-level PWM.
module seg_scan_ctrl #(
  parameter int SUB_TICKS   = 3000,
  parameter int BLANK_TICKS = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus,
  input  logic [3:0] brightness,
  input  logic [5:0] digit_en,
  output logic       frame_tick,
  output logic [7:0] seg_out,
  output logic [5:0] sel_out
);

  localparam int CNT_MAX = (BLANK_TICKS > SUB_TICKS) ? BLANK_TICKS : SUB_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(SUB_TICKS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sub_q, sub_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       bright_q, bright_d;
  logic [5:0][4:0]  shadow_q, shadow_d;
  logic [5:0][4:0]  active_q, active_d;
  logic             pending_q, pending_d;
  logic             wr_ready_q;
  logic             frame_tick_q;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       sel_q, sel_d;
  logic             wrap, apply, wr_fire, lit_d;

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    logic [6:0] s;
    s = 7'h7F;
    case (hex)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Slot sequencing: BLANK for BLANK_TICKS, then 16 sub-slots of SUB_TICKS each.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
          sub_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (cnt_q == SUB_LAST) begin
          cnt_d = '0;
          if (sub_q == 4'd15) begin
            state_d = ST_BLANK;
            sub_d   = '0;
            wrap    = (idx_q == 3'd5);
            idx_d   = wrap ? 3'd0 : idx_q + 3'd1;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Outputs are computed from next-state values so the registered pins line up with the FSM.
  always_comb begin
    bright_d = bright_q;
    if (state_q == ST_BLANK && cnt_q == '0) bright_d = brightness;

    wr_fire  = bus.wr_en && wr_ready_q && (bus.wr_addr < 3'd6);
    shadow_d = shadow_q;
    if (wr_fire) shadow_d[bus.wr_addr] = bus.wr_data;

    // A commit arriving in the wrap cycle re-arms pending and lands at the next wrap.
    apply     = wrap && pending_q;
    active_d  = apply ? shadow_q : active_q;
    pending_d = (apply ? 1'b0 : pending_q) | bus.commit;

    lit_d = (state_d == ST_ON) && digit_en[idx_d] && (bright_d > sub_d);
    sel_d = lit_d ? ~(6'd1 << idx_d) : 6'h3F;
    seg_d = lit_d ? {~active_d[idx_d][4], seg_decode(active_d[idx_d][3:0])} : 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      sub_q        <= '0;
      idx_q        <= '0;
      bright_q     <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      wr_ready_q   <= 1'b1;
      frame_tick_q <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= 6'h3F;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      idx_q        <= idx_d;
      bright_q     <= bright_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      wr_ready_q   <= ~pending_d;
      frame_tick_q <= wrap;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign bus.wr_ready = wr_ready_q;
  assign frame_tick   = frame_tick_q;
  assign seg_out      = seg_q;
  assign sel_out      = sel_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller for the board's 6-digit multiplexed seven-segment display. Requesters write per-digit values into a shadow register file through a valid/ready handshake. An explicit commit copies the shadow file into the active file only at a frame boundary, so the display never tears. The block sequences digit selection, inserts an anti-ghosting blank interval, and applies 16-level brightness PWM per digit slot.

Parameters:
SUB_TICKS, 3000, clk cycles per brightness sub-slot (16 sub-slots per digit ON phase)
BLANK_TICKS, 2000, clk cycles per digit with all selects off before the ON phase (default digit slot = 50000 cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_ready  out  1  write accepted when wr_en && wr_ready; high when no commit pending
wr_addr  in  3  digit index 0..5; 6..7 accepted and discarded
wr_data  in  5  bit4 = decimal point on, bits3:0 = hex value
commit  in  1  one-cycle request: copy shadow to active at next frame boundary
brightness  in  4  0 = dark, 15 = 15/16 duty
digit_en  in  6  per-digit enable mask, bit i = digit i
frame_tick  out  1  one-cycle pulse on digit 5 -> 0 wrap
seg_out  out  8  active-low; [7]=dp, [6:0]=g..a
sel_out  out  6  active-low digit selects; at most one low at a time

Behaviour:
- Reset (async): seg_out=8'hFF, sel_out=6'h3F, frame_tick=0, shadow and active files all 5'h00, digit index=0, FSM=BLANK, counter=0, commit_pending=0, latched brightness=0, wr_ready=1.
- All outputs are registered.
- FSM BLANK:
  - sel_out=6'h3F, seg_out=8'hFF for exactly BLANK_TICKS cycles.
  - Brightness is latched on BLANK entry.
  - Then go to ON with counter=0.
- FSM ON:
  - Lasts 16*SUB_TICKS cycles; sub_idx = counter / SUB_TICKS (0..15).
  - Digit idx is lit iff digit_en[idx] && latched_brightness > sub_idx.
  - Lit: sel_out[idx]=0 and seg_out = decode(active[idx]). Unlit: sel_out=6'h3F, seg_out=8'hFF.
  - On the last ON cycle: idx <= (idx==5) ? 0 : idx+1, and FSM returns to BLANK.
- Decode: hex 0..F to standard gfedcba patterns, active-low (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110). seg_out[7] = ~dp.
- Frame wrap: in the cycle idx goes 5 -> 0, frame_tick=1 for exactly one cycle. If commit_pending is set, active <= shadow (all six entries atomically) and commit_pending <= 0 in that same cycle.
- Commit:
  - commit=1 sets commit_pending. A commit while already pending is absorbed.
  - A commit sampled in the wrap cycle is applied at the following wrap, not the current one.
- Writes:
  - Accepted when wr_en && wr_ready; shadow[wr_addr] <= wr_data.
  - wr_ready = ~commit_pending, so writes are refused between commit and its application.
  - A write and a commit in the same cycle: the write is accepted and included in that commit.
- Boundary conditions:
  - brightness=0 or digit_en=0: display fully dark; the scan and frame_tick continue.
  - A brightness change mid-slot takes effect in the next digit slot.
  - Reset mid-frame: immediate return to reset state; pending commit and shadow contents are lost.

Test Plan:
Bench uses SUB_TICKS=2, BLANK_TICKS=3, giving a 35-cycle digit slot and a 210-cycle frame.
1. Reset, brightness=15, digit_en=6'h3F:
   - first 3 cycles sel_out=3F;
   - then sel_out=3E for 30 cycles with seg_out=8'hC0 ("0", dp off);
   - then dark for 2 cycles;
   - frame_tick pulses every 210 cycles.
2. Write addr0=5'h18, addr3=5'h07, then commit:
   - wr_ready is low until the next wrap;
   - after the wrap, digit0 shows seg_out=8'h00 (8 with dp) and digit3 shows 8'hF8 (7);
   - before the wrap, the display is unchanged.
3. brightness=4: each digit is lit for exactly 8 cycles (sub_idx 0..3) per 35-cycle slot. brightness=0: sel_out stays 3F for a full frame while frame_tick still pulses.
4. digit_en=6'b000100: only sel_out=6'b111011 is ever observed low; all other slots are dark.
5. Assert commit in the frame_tick cycle: the update appears one frame later. A write attempted while pending (wr_ready=0) leaves shadow unchanged; confirm with a second commit.
6. Assert rst_n low mid-ON-phase of digit 2: sel_out and seg_out go to 3F/FF asynchronously, active returns to 0, and scan restarts at digit 0 in BLANK.
